// File: rtl/gba_cart_frontend.sv
`timescale 1ns/1ps
// gba_cart_frontend: GBA cartridge-edge front-end.
// Synchronizes the cartridge bus pins, decodes ROM (CS, 16-bit) and SRAM
// (CS2, 8-bit) accesses and issues single-cycle read/write requests to the
// cartridge request mux. Returned read data is registered and driven back
// onto AD (ROM) or A (SRAM) while RD is low.
// Optional feature macro: GBA_CART_PREFETCH_EN (ROM read-ahead on CS fall and
// after every RD rise). Default build: ROM reads issued on RD fall.
module gba_cart_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gba_cs_n,
    input  logic        gba_cs2_n,
    input  logic        gba_rd_n,
    input  logic        gba_wr_n,
    input  logic [15:0] gba_ad_in,
    input  logic [7:0]  gba_a_in,
    output logic [15:0] gba_ad_out,
    output logic        gba_ad_oe,
    output logic [7:0]  gba_a_out,
    output logic        gba_a_oe,
    output logic        cart_rd,
    output logic        cart_wr,
    output logic [1:0]  cart_data_width,
    output logic [25:0] cart_addr,
    output logic [15:0] cart_wr_data,
    input  logic [15:0] cart_rd_data,
    input  logic        mux_rd_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_ROM, ST_SRAM} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] cs_sync, cs2_sync, rd_sync, wr_sync;
    logic [15:0] ad_sync [SYNC_STAGES];
    logic [7:0]  a_sync  [SYNC_STAGES];

    logic        cs_n_p0, cs2_n_p0, rd_n_p0, wr_n_p0;
    logic        cs_n_p1, cs2_n_p1, rd_n_p1, wr_n_p1;
    logic [15:0] ad_p0;
    logic [7:0]  a_p0;

    logic cs_fall, cs_rise, cs2_fall, cs2_rise, rd_fall, rd_rise, wr_rise;

    logic [23:0] hw_addr, hw_addr_inc;

    logic        rd_trig, wr_trig, session_end;
    logic [25:0] trig_addr, wr_addr;
    logic [1:0]  trig_w, wr_w;
    logic [15:0] wr_dat;

    logic        pending, pending_rom, discard, held, overrun;
    logic [25:0] held_addr, held_addr_nx, iss_addr;
    logic [1:0]  held_w, held_w_nx, iss_w;
    logic        held_nx, issue_rd, ovr_set, busy;

    // Overrun is a sticky debug observation point with no output port.
    logic unused_overrun;
    assign unused_overrun = overrun;

    // Pin synchronizers. Strobes reset to 0 (asserted) so a strobe already low
    // when reset releases never produces a spurious falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '0;
            cs2_sync <= '0;
            rd_sync  <= '0;
            wr_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_sync[i] <= '0;
                a_sync[i]  <= '0;
            end
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  gba_cs_n};
            cs2_sync <= {cs2_sync[SYNC_STAGES-2:0], gba_cs2_n};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0],  gba_rd_n};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0],  gba_wr_n};
            ad_sync[0] <= gba_ad_in;
            a_sync[0]  <= gba_a_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_sync[i] <= ad_sync[i-1];
                a_sync[i]  <= a_sync[i-1];
            end
        end
    end

    assign cs_n_p0  = cs_sync[SYNC_STAGES-1];
    assign cs2_n_p0 = cs2_sync[SYNC_STAGES-1];
    assign rd_n_p0  = rd_sync[SYNC_STAGES-1];
    assign wr_n_p0  = wr_sync[SYNC_STAGES-1];
    assign ad_p0    = ad_sync[SYNC_STAGES-1];
    assign a_p0     = a_sync[SYNC_STAGES-1];

    // ---- stage p0 -> p1: delayed strobe copies for edge detection ----
    // One-cycle-delayed strobes for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_p1  <= 1'b0;
            cs2_n_p1 <= 1'b0;
            rd_n_p1  <= 1'b0;
            wr_n_p1  <= 1'b0;
        end else begin
            cs_n_p1  <= cs_n_p0;
            cs2_n_p1 <= cs2_n_p0;
            rd_n_p1  <= rd_n_p0;
            wr_n_p1  <= wr_n_p0;
        end
    end

    assign cs_fall  =  cs_n_p1  & ~cs_n_p0;
    assign cs_rise  = ~cs_n_p1  &  cs_n_p0;
    assign cs2_fall =  cs2_n_p1 & ~cs2_n_p0;
    assign cs2_rise = ~cs2_n_p1 &  cs2_n_p0;
    assign rd_fall  =  rd_n_p1  & ~rd_n_p0;
    assign rd_rise  = ~rd_n_p1  &  rd_n_p0;
    assign wr_rise  = ~wr_n_p1  &  wr_n_p0;

    assign hw_addr_inc = hw_addr + 24'd1;

    // Access-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state plus read/write triggers decoded from the detected edges.
    always_comb begin
        state_nx    = state;
        rd_trig     = 1'b0;
        trig_addr   = '0;
        trig_w      = 2'b00;
        wr_trig     = 1'b0;
        wr_addr     = '0;
        wr_w        = 2'b00;
        wr_dat      = '0;
        session_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nx = ST_ROM;
`ifdef GBA_CART_PREFETCH_EN
                    rd_trig   = 1'b1;
                    trig_addr = {1'b0, a_p0, ad_p0, 1'b0};
                    trig_w    = 2'b10;
`endif
                end else if (cs2_fall && cs_n_p0) begin
                    state_nx = ST_SRAM;
                end
            end
            ST_ROM: begin
                if (cs_rise) begin
                    state_nx    = ST_IDLE;
                    session_end = 1'b1;
                end
`ifdef GBA_CART_PREFETCH_EN
                if (rd_rise) begin
                    rd_trig   = 1'b1;
                    trig_addr = {1'b0, hw_addr_inc, 1'b0};
                    trig_w    = 2'b10;
                end
`else
                if (rd_fall) begin
                    rd_trig   = 1'b1;
                    trig_addr = {1'b0, hw_addr, 1'b0};
                    trig_w    = 2'b10;
                end
`endif
                if (wr_rise) begin
                    wr_trig = 1'b1;
                    wr_addr = {1'b0, hw_addr, 1'b0};
                    wr_w    = 2'b10;
                    wr_dat  = ad_p0;
                end
            end
            ST_SRAM: begin
                if (cs2_rise) begin
                    state_nx    = ST_IDLE;
                    session_end = 1'b1;
                end
                if (rd_fall) begin
                    rd_trig   = 1'b1;
                    trig_addr = {1'b1, 9'b0, ad_p0};
                    trig_w    = 2'b01;
                end
                if (wr_rise) begin
                    wr_trig = 1'b1;
                    wr_addr = {1'b1, 9'b0, ad_p0};
                    wr_w    = 2'b01;
                    wr_dat  = {8'h00, a_p0};
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = pending & ~mux_rd_valid;

    // Read issue arbitration: one read outstanding, one held, the rest dropped.
    // A write in the same cycle takes the request port; the read waits.
    always_comb begin
        issue_rd     = 1'b0;
        iss_addr     = held_addr;
        iss_w        = held_w;
        held_nx      = held;
        held_addr_nx = held_addr;
        held_w_nx    = held_w;
        ovr_set      = 1'b0;
        if (session_end) begin
            held_nx = 1'b0;
        end else begin
            if (held && !busy && !wr_trig) begin
                issue_rd = 1'b1;
                held_nx  = 1'b0;
            end
            if (rd_trig) begin
                if (!issue_rd && !held && !busy && !wr_trig) begin
                    issue_rd = 1'b1;
                    iss_addr = trig_addr;
                    iss_w    = trig_w;
                end else if (!held_nx) begin
                    held_nx      = 1'b1;
                    held_addr_nx = trig_addr;
                    held_w_nx    = trig_w;
                end else begin
                    ovr_set = 1'b1;
                end
            end
        end
    end

    // ---- stage p1 -> p2: registered requests, read tracking, bus drive ----
    // Hardware address counter, read tracking and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_addr         <= '0;
            pending         <= 1'b0;
            pending_rom     <= 1'b0;
            discard         <= 1'b0;
            held            <= 1'b0;
            held_addr       <= '0;
            held_w          <= 2'b00;
            overrun         <= 1'b0;
            cart_rd         <= 1'b0;
            cart_wr         <= 1'b0;
            cart_addr       <= '0;
            cart_data_width <= 2'b00;
            cart_wr_data    <= '0;
            gba_ad_out      <= '0;
            gba_a_out       <= '0;
            gba_ad_oe       <= 1'b0;
            gba_a_oe        <= 1'b0;
        end else begin
            if (state == ST_IDLE && cs_fall)
                hw_addr <= {a_p0, ad_p0};
            else if (state == ST_ROM && (rd_rise || wr_rise))
                hw_addr <= hw_addr_inc;

            if (issue_rd) begin
                pending     <= 1'b1;
                pending_rom <= (iss_w == 2'b10);
            end else if (mux_rd_valid) begin
                pending <= 1'b0;
            end

            if (session_end && busy) discard <= 1'b1;
            else if (mux_rd_valid)   discard <= 1'b0;

            held      <= held_nx;
            held_addr <= held_addr_nx;
            held_w    <= held_w_nx;
            if (ovr_set) overrun <= 1'b1;

            cart_rd <= issue_rd;
            cart_wr <= wr_trig;
            if (wr_trig) begin
                cart_addr       <= wr_addr;
                cart_data_width <= wr_w;
                cart_wr_data    <= wr_dat;
            end else if (issue_rd) begin
                cart_addr       <= iss_addr;
                cart_data_width <= iss_w;
            end

            if (mux_rd_valid && pending && !discard) begin
                if (pending_rom) gba_ad_out <= cart_rd_data;
                else             gba_a_out  <= cart_rd_data[7:0];
            end

            gba_ad_oe <= (state == ST_ROM)  && !rd_n_p0;
            gba_a_oe  <= (state == ST_SRAM) && !rd_n_p0;
        end
    end

endmodule

// File: tb/tb_gba_cart_frontend.sv
`timescale 1ns/1ps
// Testbench for gba_cart_frontend: table-driven write vectors plus directed
// ROM burst, address wrap, SRAM read, discard and reset sequences.
module tb_gba_cart_frontend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gba_cs_n = 1'b1, gba_cs2_n = 1'b1, gba_rd_n = 1'b1, gba_wr_n = 1'b1;
    logic [15:0] gba_ad_in = '0;
    logic [7:0]  gba_a_in = '0;
    logic [15:0] gba_ad_out;
    logic        gba_ad_oe;
    logic [7:0]  gba_a_out;
    logic        gba_a_oe;
    logic        cart_rd, cart_wr;
    logic [1:0]  cart_data_width;
    logic [25:0] cart_addr;
    logic [15:0] cart_wr_data;
    logic [15:0] cart_rd_data = '0;
    logic        mux_rd_valid = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    gba_cart_frontend #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .gba_cs_n(gba_cs_n), .gba_cs2_n(gba_cs2_n), .gba_rd_n(gba_rd_n), .gba_wr_n(gba_wr_n),
        .gba_ad_in(gba_ad_in), .gba_a_in(gba_a_in),
        .gba_ad_out(gba_ad_out), .gba_ad_oe(gba_ad_oe),
        .gba_a_out(gba_a_out), .gba_a_oe(gba_a_oe),
        .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_data_width(cart_data_width),
        .cart_addr(cart_addr), .cart_wr_data(cart_wr_data),
        .cart_rd_data(cart_rd_data), .mux_rd_valid(mux_rd_valid)
    );

    always #5 clk = ~clk;

    // Request logs captured mid-cycle.
    logic [25:0] rd_log [64];
    logic [1:0]  rd_w_log [64];
    logic [25:0] wr_a_log [64];
    logic [15:0] wr_d_log [64];
    logic [1:0]  wr_w_log [64];
    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cart_rd && rd_cnt < 64) begin
                rd_log[rd_cnt]   = cart_addr;
                rd_w_log[rd_cnt] = cart_data_width;
                rd_cnt++;
            end
            if (cart_wr && wr_cnt < 64) begin
                wr_a_log[wr_cnt] = cart_addr;
                wr_d_log[wr_cnt] = cart_wr_data;
                wr_w_log[wr_cnt] = cart_data_width;
                wr_cnt++;
            end
        end
    end

    // Mux model: answers each cart_rd after mux_lat cycles with the next queued word.
    logic [15:0] rsp_q [$];
    int mux_lat = 1;
    int rsp_cd = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_cd       = -1;
            mux_rd_valid = 1'b0;
        end else begin
            if (mux_rd_valid) mux_rd_valid = 1'b0;
            if (cart_rd) rsp_cd = mux_lat;
            else if (rsp_cd > 0) rsp_cd--;
            if (rsp_cd == 0) begin
                mux_rd_valid = 1'b1;
                cart_rd_data = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hDEAD;
                rsp_cd       = -1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_start(input logic [23:0] addr);
        gba_ad_in = addr[15:0];
        gba_a_in  = addr[23:16];
        gba_cs_n  = 1'b0;
        cyc(6);
    endtask

    task automatic rom_end();
        gba_cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic rd_pulse();
        gba_rd_n = 1'b0;
        cyc(8);
        gba_rd_n = 1'b1;
        cyc(6);
    endtask

    typedef struct {
        bit          rom;
        logic [23:0] addr;
        logic [15:0] wdat;
        logic [7:0]  a;
        logic [25:0] exp_addr;
        logic [15:0] exp_data;
        logic [1:0]  exp_w;
    } vec_t;

    vec_t tab [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] burst_exp [3];
        logic [25:0] burst_addr [4];
        int n_burst;

        tab[0] = '{1'b1, 24'h123456, 16'hBEEF, 8'h00, 26'h02468AC, 16'hBEEF, 2'b10};
        tab[1] = '{1'b1, 24'hFFFFFF, 16'h0001, 8'h00, 26'h1FFFFFE, 16'h0001, 2'b10};
        tab[2] = '{1'b0, 24'h001234, 16'h0000, 8'h5A, 26'h2001234, 16'h005A, 2'b01};
        tab[3] = '{1'b0, 24'h00FFFF, 16'h0000, 8'hFF, 26'h200FFFF, 16'h00FF, 2'b01};
        tab[4] = '{1'b0, 24'h000000, 16'h0000, 8'h01, 26'h2000000, 16'h0001, 2'b01};
        burst_exp  = '{16'hA001, 16'hA002, 16'hA003};
        burst_addr = '{26'h0000200, 26'h0000202, 26'h0000204, 26'h0000206};
`ifdef GBA_CART_PREFETCH_EN
        n_burst = 4;
`else
        n_burst = 3;
`endif

        // Reset state
        cyc(3);
        chk("rst cart_rd", cart_rd, 0);
        chk("rst cart_wr", cart_wr, 0);
        chk("rst ad_oe", gba_ad_oe, 0);
        chk("rst a_oe", gba_a_oe, 0);
        chk("rst width", cart_data_width, 0);
        chk("rst addr", cart_addr, 0);
        chk("rst wr_data", cart_wr_data, 0);
        chk("rst ad_out/a_out", {gba_ad_out, gba_a_out}, 0);
        rst_n = 1'b1;
        cyc(6);

        // ROM burst from 0x000100
        rsp_q.delete();
        rsp_q.push_back(16'hA001); rsp_q.push_back(16'hA002);
        rsp_q.push_back(16'hA003); rsp_q.push_back(16'hA003);
        base = rd_cnt;
        rom_start(24'h000100);
        for (int k = 0; k < 3; k++) begin
            gba_rd_n = 1'b0;
            cyc(8);
            chk("burst ad_oe low-RD", gba_ad_oe, 1);
            chk("burst ad_out", gba_ad_out, burst_exp[k]);
            gba_rd_n = 1'b1;
            cyc(6);
            chk("burst ad_oe high-RD", gba_ad_oe, 0);
        end
        rom_end();
        chk("burst read count", rd_cnt - base, n_burst);
        for (int k = 0; k < n_burst; k++)
            chk("burst cart_addr", rd_log[base + k], burst_addr[k]);

        // CS rise with a read outstanding; late data must be swallowed
        rsp_q.delete();
        rsp_q.push_back(16'hBAD0);
        rsp_q.push_back(16'h5555);
        mux_lat = 30;
        rom_start(24'h000050);
        gba_rd_n = 1'b0;
        cyc(6);
        gba_rd_n = 1'b1;
        cyc(4);
        rom_end();
        base = rd_cnt;
        rom_start(24'h000010);
        cyc(30);
        chk("discard ad_out kept", gba_ad_out, 16'hA003);
        mux_lat = 2;
        gba_rd_n = 1'b0;
        cyc(40);
        chk("after discard ad_out", gba_ad_out, 16'h5555);
        chk("after discard addr", rd_log[base], 26'h0000020);
        gba_rd_n = 1'b1;
        cyc(6);
        rom_end();
        mux_lat = 1;
        cyc(10);

        // ROM address wrap
        rsp_q.delete();
        rsp_q.push_back(16'h0E01); rsp_q.push_back(16'h0E02); rsp_q.push_back(16'h0E03);
        base = rd_cnt;
        rom_start(24'hFFFFFF);
        rd_pulse();
        rd_pulse();
        rom_end();
        chk("wrap first addr", rd_log[base], 26'h1FFFFFE);
        chk("wrap second addr", rd_log[base + 1], 26'h0000000);

        // Table-driven writes (ROM and SRAM)
        for (int i = 0; i < 5; i++) begin
            rsp_q.delete();
            base = wr_cnt;
            if (tab[i].rom) begin
                rom_start(tab[i].addr);
                gba_ad_in = tab[i].wdat;
                gba_wr_n  = 1'b0;
                cyc(6);
                gba_wr_n  = 1'b1;
                cyc(6);
                rom_end();
            end else begin
                gba_ad_in = tab[i].addr[15:0];
                gba_a_in  = tab[i].a;
                gba_cs2_n = 1'b0;
                cyc(6);
                gba_wr_n  = 1'b0;
                cyc(6);
                gba_wr_n  = 1'b1;
                cyc(6);
                gba_cs2_n = 1'b1;
                cyc(6);
            end
            chk("wr count", wr_cnt - base, 1);
            chk("wr addr", wr_a_log[base], tab[i].exp_addr);
            chk("wr data", wr_d_log[base], tab[i].exp_data);
            chk("wr width", wr_w_log[base], tab[i].exp_w);
        end

        // SRAM read
        rsp_q.delete();
        rsp_q.push_back(16'h00C3);
        base = rd_cnt;
        gba_ad_in = 16'h0042;
        gba_cs2_n = 1'b0;
        cyc(6);
        gba_rd_n = 1'b0;
        cyc(8);
        chk("sram a_oe low-RD", gba_a_oe, 1);
        chk("sram ad_oe stays off", gba_ad_oe, 0);
        chk("sram a_out", gba_a_out, 8'hC3);
        chk("sram rd addr", rd_log[base], 26'h2000042);
        chk("sram rd width", rd_w_log[base], 2'b01);
        gba_rd_n = 1'b1;
        cyc(6);
        chk("sram a_oe high-RD", gba_a_oe, 0);
        gba_cs2_n = 1'b1;
        cyc(6);

        // Reset in the middle of a ROM burst
        rsp_q.delete();
        rsp_q.push_back(16'h1111);
        rom_start(24'h000200);
        gba_rd_n = 1'b0;
        cyc(6);
        chk("pre-reset ad_oe", gba_ad_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst cart_rd", cart_rd, 0);
        chk("mid rst cart_wr", cart_wr, 0);
        chk("mid rst ad_oe", gba_ad_oe, 0);
        chk("mid rst a_oe", gba_a_oe, 0);
        chk("mid rst width", cart_data_width, 0);
        chk("mid rst addr", cart_addr, 0);
        chk("mid rst wr_data", cart_wr_data, 0);
        chk("mid rst ad_out", gba_ad_out, 0);
        chk("mid rst a_out", gba_a_out, 0);
        base = rd_cnt + wr_cnt;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        gba_rd_n = 1'b1;
        cyc(6);
        rom_end();
        chk("no requests after reset", rd_cnt + wr_cnt - base, 0);

        // New session resumes normally
        rsp_q.delete();
        rsp_q.push_back(16'h0BEE);
        base = rd_cnt;
        rom_start(24'h000300);
        rd_pulse();
        rom_end();
        chk("resume rd addr", rd_log[base], 26'h0000600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
